// File: rtl/keypad_request_decoder.sv
// Keypad front end: debounces scanner samples into single key events, builds a
// two-digit floor number from digit keys and queues confirmed floors for the scheduler.
module keypad_request_decoder #(
  parameter int HOLD_CYCLES    = 4,
  parameter int RELEASE_CYCLES = 4,
  parameter int FLOORS         = 16,
  parameter int DEPTH          = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] buttonBus,
  input  logic       pressed,
  input  logic       req_ready,
  output logic       req_valid,
  output logic [6:0] req_floor,
  output logic       key_evt,
  output logic [3:0] key_code,
  output logic [6:0] entry_value,
  output logic [1:0] digit_count,
  output logic       err
);

  localparam int CNT_MAX = (HOLD_CYCLES > RELEASE_CYCLES) ? HOLD_CYCLES : RELEASE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int PTR_W   = $clog2(DEPTH);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(RELEASE_CYCLES);
  localparam logic [PTR_W:0]   FULL_OCC  = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_HELD,
    S_RELEASE
  } state_t;

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_cnt, w_cnt_next;
  logic [3:0]       r_latch, w_latch_next;
  logic             w_accept;

  logic [6:0]       r_entry, w_entry_next;
  logic [1:0]       r_digits, w_digits_next;
  logic             w_push, w_err_next;

  logic [6:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]   r_occ;
  logic             w_full, w_pop;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_latch <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_latch <= w_latch_next;
    end
  end

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_latch_next = r_latch;
    unique case (r_state)
      S_IDLE: begin
        if (!pressed) begin
          w_latch_next = buttonBus;
          w_cnt_next   = CNT_W'(1);
          w_state_next = S_DEBOUNCE;
        end
      end
      S_DEBOUNCE: begin
        if (pressed || (buttonBus != r_latch)) begin
          w_cnt_next   = '0;
          w_state_next = S_IDLE;
        end else if (r_cnt == HOLD_LAST) begin
          w_cnt_next   = '0;
          w_state_next = S_HELD;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_HELD: begin
        if (pressed) begin
          w_cnt_next   = CNT_W'(1);
          w_state_next = S_RELEASE;
        end
      end
      S_RELEASE: begin
        // A press seen while releasing is a contact bounce, not a new key.
        if (!pressed) begin
          w_cnt_next   = '0;
          w_state_next = S_HELD;
        end else if (r_cnt == REL_LAST) begin
          w_cnt_next   = '0;
          w_state_next = S_IDLE;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_cnt_next   = '0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_accept = (r_state == S_DEBOUNCE) && !pressed && (buttonBus == r_latch) &&
               (r_cnt == HOLD_LAST);
  end

  assign w_full    = (r_occ == FULL_OCC);
  assign req_valid = (r_occ != '0);
  assign w_pop     = req_valid && req_ready;
  assign req_floor = req_valid ? r_mem[r_rd_ptr] : 7'd0;

  always_comb begin
    w_entry_next  = r_entry;
    w_digits_next = r_digits;
    w_push        = 1'b0;
    w_err_next    = 1'b0;
    if (w_accept) begin
      if (r_latch <= 4'd9) begin
        if (r_digits < 2'd2) begin
          w_entry_next  = r_entry * 7'd10 + {3'b000, r_latch};
          w_digits_next = r_digits + 2'd1;
        end else begin
          w_err_next = 1'b1;
        end
      end else if (r_latch == 4'hA) begin
        if (r_digits == 2'd0) begin
          w_err_next = 1'b1;
        end else if (r_entry >= 7'(FLOORS)) begin
          w_err_next    = 1'b1;
          w_entry_next  = '0;
          w_digits_next = '0;
        end else if (w_full) begin
          // Full is judged before any same-cycle pop; the entry stays for a retry.
          w_err_next = 1'b1;
        end else begin
          w_push        = 1'b1;
          w_entry_next  = '0;
          w_digits_next = '0;
        end
      end else if (r_latch == 4'hB) begin
        w_entry_next  = '0;
        w_digits_next = '0;
      end else begin
        w_err_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_entry     <= '0;
      r_digits    <= '0;
      key_evt     <= 1'b0;
      key_code    <= '0;
      err         <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_occ       <= '0;
    end else begin
      r_entry  <= w_entry_next;
      r_digits <= w_digits_next;
      key_evt  <= w_accept;
      err      <= w_err_next;
      if (w_accept) key_code <= r_latch;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + (PTR_W + 1)'(1);
        2'b01:   r_occ <= r_occ - (PTR_W + 1)'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  // NOTE: the storage array has no reset; occupancy gates req_floor so stale data never escapes.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= r_entry;
  end

  assign entry_value = r_entry;
  assign digit_count = r_digits;

endmodule

// File: tb/tb_keypad_request_decoder.sv
// Self-checking bench: directed keypress table, hand-written FIFO / bounce / reset
// sequences, then random keypad traffic compared every cycle against a queue-based model.
module tb_keypad_request_decoder;

  localparam int HOLD_CYCLES    = 4;
  localparam int RELEASE_CYCLES = 4;
  localparam int FLOORS         = 16;
  localparam int DEPTH          = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] buttonBus;
  logic       pressed;
  logic       req_ready;
  logic       req_valid;
  logic [6:0] req_floor;
  logic       key_evt;
  logic [3:0] key_code;
  logic [6:0] entry_value;
  logic [1:0] digit_count;
  logic       err;

  keypad_request_decoder #(
    .HOLD_CYCLES(HOLD_CYCLES), .RELEASE_CYCLES(RELEASE_CYCLES),
    .FLOORS(FLOORS), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .buttonBus(buttonBus), .pressed(pressed),
    .req_ready(req_ready), .req_valid(req_valid), .req_floor(req_floor),
    .key_evt(key_evt), .key_code(key_code), .entry_value(entry_value),
    .digit_count(digit_count), .err(err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int evt_seen = 0;
  int err_seen = 0;
  int popped[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: keypress qualified by run lengths of samples, entry kept as an
  // integer, request FIFO kept as a queue.
  int         m_run, m_rel;
  bit         m_locked;
  logic [3:0] m_run_code;
  int         m_entry, m_digits;
  int         m_q[$];
  bit         m_evt, m_err;
  int         m_code;

  task automatic model_reset();
    m_run = 0; m_rel = 0; m_locked = 0; m_run_code = 0;
    m_entry = 0; m_digits = 0; m_q.delete();
    m_evt = 0; m_err = 0; m_code = 0;
  endtask

  task automatic model_step(input logic p, input logic [3:0] c, input logic rdy);
    bit acc = 0;
    bit do_pop = rdy && (m_q.size() > 0);
    bit full = (m_q.size() == DEPTH);
    if (m_locked) begin
      // Re-armed only after RELEASE_CYCLES+1 unbroken released samples.
      if (p) begin
        m_rel++;
        if (m_rel == RELEASE_CYCLES + 1) begin m_locked = 0; m_rel = 0; end
      end else m_rel = 0;
    end else if (m_run == 0) begin
      if (!p) begin m_run = 1; m_run_code = c; end
    end else if (p || c != m_run_code) begin
      m_run = 0;
    end else begin
      m_run++;
      if (m_run == HOLD_CYCLES) begin acc = 1; m_locked = 1; m_run = 0; m_rel = 0; end
    end
    m_evt = acc;
    m_err = 0;
    if (do_pop) void'(m_q.pop_front());
    if (acc) begin
      m_code = int'(m_run_code);
      if (m_run_code <= 4'd9) begin
        if (m_digits < 2) begin m_entry = m_entry * 10 + int'(m_run_code); m_digits++; end
        else m_err = 1;
      end else if (m_run_code == 4'hA) begin
        if (m_digits == 0) m_err = 1;
        else if (m_entry >= FLOORS) begin m_err = 1; m_entry = 0; m_digits = 0; end
        else if (full) m_err = 1;
        else begin m_q.push_back(m_entry); m_entry = 0; m_digits = 0; end
      end else if (m_run_code == 4'hB) begin
        m_entry = 0; m_digits = 0;
      end else m_err = 1;
    end
  endtask

  task automatic compare_all();
    check("key_evt", 32'(key_evt), 32'(m_evt));
    check("key_code", 32'(key_code), 32'(m_code));
    check("err", 32'(err), 32'(m_err));
    check("entry_value", 32'(entry_value), 32'(m_entry));
    check("digit_count", 32'(digit_count), 32'(m_digits));
    check("req_valid", 32'(req_valid), 32'(m_q.size() > 0));
    check("req_floor", 32'(req_floor), (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
  endtask

  task automatic step(input logic p, input logic [3:0] c, input logic rdy);
    if (rdy && req_valid) popped.push_back(int'(req_floor));
    pressed = p; buttonBus = c; req_ready = rdy;
    @(posedge clk);
    #1;
    model_step(p, c, rdy);
    if (key_evt) evt_seen++;
    if (err) err_seen++;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    model_reset();
    check("rst_key_evt", 32'(key_evt), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_req_valid", 32'(req_valid), 32'd0);
    check("rst_req_floor", 32'(req_floor), 32'd0);
    check("rst_key_code", 32'(key_code), 32'd0);
    check("rst_entry", 32'(entry_value), 32'd0);
    check("rst_digits", 32'(digit_count), 32'd0);
    rst = 1'b1;
  endtask

  // Hold a key for 'hold' samples then release for 'rel'; req_ready is raised only on
  // held sample index 'rdy_idx' (-1 for never).
  task automatic press(input logic [3:0] code, input int hold, input int rel, input int rdy_idx);
    for (int i = 0; i < hold; i++) step(1'b0, code, i == rdy_idx);
    for (int i = 0; i < rel; i++) step(1'b1, 4'($urandom_range(0, 15)), 1'b0);
  endtask

  typedef struct {
    logic [3:0] code;
    int         hold;
    int         evts;
    int         errs;
    int         entry;
    int         digits;
    logic       valid;
    int         floor_no;
  } row_t;

  row_t rows[15];

  initial begin
    int e0, r0;
    rst = 1'b0; pressed = 1'b1; buttonBus = '0; req_ready = 1'b0;
    #12;
    do_reset();

    rows[0]  = '{4'h7, 3, 0, 0, 0,  0, 1'b0, 0};
    rows[1]  = '{4'h7, 4, 1, 0, 7,  1, 1'b0, 0};
    rows[2]  = '{4'hB, 4, 1, 0, 0,  0, 1'b0, 0};
    rows[3]  = '{4'h1, 4, 1, 0, 1,  1, 1'b0, 0};
    rows[4]  = '{4'h2, 4, 1, 0, 12, 2, 1'b0, 0};
    rows[5]  = '{4'hA, 4, 1, 0, 0,  0, 1'b1, 12};
    rows[6]  = '{4'h1, 4, 1, 0, 1,  1, 1'b1, 12};
    rows[7]  = '{4'h6, 4, 1, 0, 16, 2, 1'b1, 12};
    rows[8]  = '{4'hA, 4, 1, 1, 0,  0, 1'b1, 12};
    rows[9]  = '{4'hA, 4, 1, 1, 0,  0, 1'b1, 12};
    rows[10] = '{4'h1, 4, 1, 0, 1,  1, 1'b1, 12};
    rows[11] = '{4'h2, 4, 1, 0, 12, 2, 1'b1, 12};
    rows[12] = '{4'h3, 6, 1, 1, 12, 2, 1'b1, 12};
    rows[13] = '{4'hB, 4, 1, 0, 0,  0, 1'b1, 12};
    rows[14] = '{4'hD, 4, 1, 1, 0,  0, 1'b1, 12};

    foreach (rows[i]) begin
      e0 = evt_seen; r0 = err_seen;
      press(rows[i].code, rows[i].hold, RELEASE_CYCLES + 1, -1);
      check($sformatf("row%0d_evts", i), 32'(evt_seen - e0), 32'(rows[i].evts));
      check($sformatf("row%0d_errs", i), 32'(err_seen - r0), 32'(rows[i].errs));
      check($sformatf("row%0d_entry", i), 32'(entry_value), 32'(rows[i].entry));
      check($sformatf("row%0d_digits", i), 32'(digit_count), 32'(rows[i].digits));
      check($sformatf("row%0d_valid", i), 32'(req_valid), 32'(rows[i].valid));
      check($sformatf("row%0d_floor", i), 32'(req_floor), 32'(rows[i].floor_no));
    end

    // Drain the 12, fill to full, then a rejected push racing a pop.
    step(1'b1, 4'h0, 1'b1);
    check("drain_valid", 32'(req_valid), 32'd0);
    popped.delete();
    press(4'h3, 4, 5, -1); press(4'hA, 4, 5, -1);
    press(4'h5, 4, 5, -1); press(4'hA, 4, 5, -1);
    press(4'h9, 4, 5, -1); press(4'hA, 4, 5, -1);
    press(4'h0, 4, 5, -1); press(4'hA, 4, 5, -1);
    press(4'h7, 4, 5, -1);
    r0 = err_seen;
    press(4'hA, 4, 5, HOLD_CYCLES - 1);
    check("full_push_err", 32'(err_seen - r0), 32'd1);
    check("full_keep_entry", 32'(entry_value), 32'd7);
    check("full_keep_digits", 32'(digit_count), 32'd1);
    for (int i = 0; i < 6; i++) step(1'b1, 4'h0, 1'b1);
    check("pop_count", 32'(popped.size()), 32'd4);
    if (popped.size() == 4) begin
      check("pop0", 32'(popped[0]), 32'd3);
      check("pop1", 32'(popped[1]), 32'd5);
      check("pop2", 32'(popped[2]), 32'd9);
      check("pop3", 32'(popped[3]), 32'd0);
    end
    check("empty_after_pops", 32'(req_valid), 32'd0);

    // Release bounce: one press despite the key reappearing mid-release.
    e0 = evt_seen;
    for (int i = 0; i < 4; i++) step(1'b0, 4'h4, 1'b0);
    for (int i = 0; i < 2; i++) step(1'b1, 4'h0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 4'h4, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 4'h0, 1'b0);
    check("bounce_evts", 32'(evt_seen - e0), 32'd1);
    check("bounce_entry", 32'(entry_value), 32'd74);

    // Reset in the middle of debouncing; the still-held key needs fresh samples.
    step(1'b0, 4'h5, 1'b0);
    step(1'b0, 4'h5, 1'b0);
    do_reset();
    e0 = evt_seen;
    for (int i = 0; i < HOLD_CYCLES - 1; i++) step(1'b0, 4'h5, 1'b0);
    check("post_rst_no_evt", 32'(evt_seen - e0), 32'd0);
    step(1'b0, 4'h5, 1'b0);
    check("post_rst_evt", 32'(evt_seen - e0), 32'd1);
    check("post_rst_code", 32'(key_code), 32'd5);
    for (int i = 0; i < 5; i++) step(1'b1, 4'h0, 1'b0);

    // Random traffic: glitchy presses, short holds, bouncy releases, random ready.
    for (int k = 0; k < 350; k++) begin
      int r;
      int hold;
      int rel;
      logic [3:0] code;
      r = $urandom_range(0, 15);
      if (r < 10) code = 4'(r);
      else if (r < 13) code = 4'hA;
      else if (r == 13) code = 4'hB;
      else code = 4'($urandom_range(12, 15));
      hold = $urandom_range(1, 7);
      rel = $urandom_range(1, 7);
      for (int i = 0; i < hold; i++) begin
        logic [3:0] c;
        c = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : code;
        step(1'b0, c, $urandom_range(0, 3) == 0);
      end
      for (int i = 0; i < rel; i++)
        step($urandom_range(0, 7) != 0, 4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
